// File: rtl/cdc_event_sender.sv
// -----------------------------------------------------------------------------
// cdc_event_sender
//
// Purpose:
//   Source-domain half of a four-phase request/acknowledge clock-domain
//   crossing for timestamp-like payloads. Payloads offered on the
//   event_valid/event_ready interface are buffered in a small FIFO. Each one
//   is then presented to the destination domain on data_out, qualified by
//   req_out. The asynchronous acknowledge is resynchronised into clk_input
//   before the handshake FSM uses it. A payload offered while the FIFO is
//   full is dropped and recorded in a sticky flag and a saturating counter.
//
// Parameters:
//   DATA_W       payload width in bits
//   DEPTH        FIFO entries (power of 2, 2..16)
//   SYNC_STAGES  ack synchronizer depth (values below 2 behave as 2)
//
// Ports:
//   clk_input       source-domain clock
//   reset           asynchronous reset, active-high
//   event_valid     payload offered this cycle
//   event_data      payload to transfer
//   event_ready     FIFO can accept a payload (NOT full)
//   req_out         four-phase request, driven from a flop
//   data_out        payload presented to the destination, driven from flops
//   ack_in          asynchronous acknowledge from the destination
//   busy            handshake in progress or FIFO non-empty
//   overflow        sticky: at least one payload was dropped
//   drop_count      saturating count of dropped payloads
//   clear_overflow  clears overflow and drop_count (a same-edge drop wins)
// -----------------------------------------------------------------------------
module cdc_event_sender #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_input,
  input  logic              reset,
  input  logic              event_valid,
  input  logic [DATA_W-1:0] event_data,
  output logic              event_ready,
  output logic              req_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              ack_in,
  output logic              busy,
  output logic              overflow,
  output logic [7:0]        drop_count,
  input  logic              clear_overflow
);

  // ---------------------------------------------------------------------------
  // Derived sizes
  // ---------------------------------------------------------------------------
  localparam int N_SYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Acknowledge synchronizer
  // Only the final stage (ack_s) is ever looked at; the earlier stages exist
  // purely to let a metastable first flop settle.
  // ---------------------------------------------------------------------------
  logic [N_SYNC-1:0] ack_sync;
  logic              ack_s;

  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // samples the pre-edge value of its neighbours, which is what makes this
  // shift register a chain of N_SYNC flops rather than a single wire.
  always_ff @(posedge clk_input or posedge reset) begin
    if (reset) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[N_SYNC-2:0], ack_in};
    end
  end

  assign ack_s = ack_sync[N_SYNC-1];

  // ---------------------------------------------------------------------------
  // Payload FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              drop;
  logic              pop;

  state_t            state;

  assign fifo_full   = (count == FULL_COUNT);
  assign fifo_empty  = (count == '0);

  // Ready comes straight from the registered count: a slot freed by a pop on
  // this same edge is not advertised until the next cycle.
  assign event_ready = ~fifo_full;
  assign push        = event_valid & ~fifo_full;
  assign drop        = event_valid &  fifo_full;

  // A new handshake may only start once the destination has released its
  // previous acknowledge, both from IDLE and directly from RELEASE.
  assign pop = ~fifo_empty & ~ack_s & ((state == IDLE) | (state == RELEASE));

  // NOTE: the storage array has no reset. Its contents are only ever read
  // behind a non-zero count, and the count and pointers are reset, so
  // leaving the array unreset keeps it a plain register file or RAM.
  always_ff @(posedge clk_input) begin
    if (push) begin
      mem[wr_ptr] <= event_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap modulo DEPTH naturally.
  always_ff @(posedge clk_input or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      // A push and a pop on the same edge leave the occupancy unchanged.
      unique case ({push, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Four-phase handshake FSM
  // req_out and data_out are registered here so the destination sees clean,
  // glitch-free signals; data_out is only loaded on a pop and otherwise holds,
  // including after req_out has fallen.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_input or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      req_out  <= 1'b0;
      data_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // A stale or stuck-high ack keeps pop low, so the FSM waits here.
          if (pop) begin
            state    <= REQ;
            req_out  <= 1'b1;
            data_out <= mem[rd_ptr];
          end
        end

        REQ: begin
          if (ack_s) begin
            state   <= RELEASE;
            req_out <= 1'b0;
          end
        end

        RELEASE: begin
          if (!ack_s) begin
            if (pop) begin
              state    <= REQ;
              req_out  <= 1'b1;
              data_out <= mem[rd_ptr];
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state   <= IDLE;
          req_out <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE) | ~fifo_empty;

  // ---------------------------------------------------------------------------
  // Drop accounting
  // A drop on the same edge as a clear restarts the count at one instead of
  // being lost.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_input or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_overflow) begin
        drop_count <= 8'd1;
      end else if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end else if (clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end
  end

endmodule

// File: tb/tb_cdc_event_sender.sv
// -----------------------------------------------------------------------------
// tb_cdc_event_sender
//
// Directed bench for cdc_event_sender with DATA_W=16, DEPTH=4, SYNC_STAGES=2.
// The destination side is played by the stimulus itself: ack_in is raised
// after req_out is seen and lowered after req_out falls. Outputs are sampled
// 1 time unit after each rising edge of clk_input; inputs change at the same
// point so they are stable well before the next edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cdc_event_sender;

  localparam int DATA_W      = 16;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;

  logic              clk_input = 1'b0;
  logic              reset;
  logic              event_valid;
  logic [DATA_W-1:0] event_data;
  logic              event_ready;
  logic              req_out;
  logic [DATA_W-1:0] data_out;
  logic              ack_in;
  logic              busy;
  logic              overflow;
  logic [7:0]        drop_count;
  logic              clear_overflow;

  int checks   = 0;
  int failures = 0;

  cdc_event_sender #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk_input      (clk_input),
    .reset          (reset),
    .event_valid    (event_valid),
    .event_data     (event_data),
    .event_ready    (event_ready),
    .req_out        (req_out),
    .data_out       (data_out),
    .ack_in         (ack_in),
    .busy           (busy),
    .overflow       (overflow),
    .drop_count     (drop_count),
    .clear_overflow (clear_overflow)
  );

  always #5 clk_input = ~clk_input;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_input);
    #1;
  endtask

  // Advance until req_out reaches level or the budget runs out; the final
  // comparison doubles as the timeout check.
  task automatic wait_req(input string tag, input logic level, input int budget,
                          output int n);
    n = 0;
    while (req_out !== level && n < budget) begin
      tick();
      n++;
    end
    check(tag, {31'd0, req_out}, {31'd0, level});
  endtask

  // One complete four-phase handshake as seen from the destination.
  task automatic handshake(input string tag, input logic [DATA_W-1:0] exp_data,
                           output int gap);
    int n;
    wait_req({tag, "_req_rise"}, 1'b1, 50, gap);
    check({tag, "_data"}, {16'd0, data_out}, {16'd0, exp_data});
    ack_in = 1'b1;
    wait_req({tag, "_req_fall"}, 1'b0, 50, n);
    ack_in = 1'b0;
  endtask

  int gap;
  int n;
  int rises;

  initial begin
    reset          = 1'b1;
    event_valid    = 1'b0;
    event_data     = '0;
    ack_in         = 1'b0;
    clear_overflow = 1'b0;
    tick();
    tick();

    // ---------------- Reset state ----------------
    check("rst_req_out",    {31'd0, req_out},     32'd0);
    check("rst_data_out",   {16'd0, data_out},    32'd0);
    check("rst_ready",      {31'd0, event_ready}, 32'd1);
    check("rst_busy",       {31'd0, busy},        32'd0);
    check("rst_overflow",   {31'd0, overflow},    32'd0);
    check("rst_drop_count", {24'd0, drop_count},  32'd0);
    reset = 1'b0;
    tick();
    tick();
    tick();

    // ---------------- Single transfer ----------------
    event_valid = 1'b1;
    event_data  = 16'h1234;
    tick();                                   // edge N: accepted
    event_valid = 1'b0;
    check("single_req_edge_n", {31'd0, req_out}, 32'd0);
    check("single_busy_queued", {31'd0, busy}, 32'd1);
    tick();                                   // edge N+1: request raised
    check("single_req_edge_n1", {31'd0, req_out}, 32'd1);
    check("single_data", {16'd0, data_out}, 32'h1234);
    tick();
    tick();                                   // three cycles after req
    ack_in = 1'b1;
    tick();                                   // ack first sampled
    check("single_req_hold0", {31'd0, req_out}, 32'd1);
    tick();                                   // ack_s now high
    check("single_req_hold1", {31'd0, req_out}, 32'd1);
    tick();                                   // SYNC_STAGES edges after sampling
    check("single_req_fall", {31'd0, req_out}, 32'd0);
    check("single_data_hold", {16'd0, data_out}, 32'h1234);
    ack_in = 1'b0;
    tick();
    tick();                                   // ack_s low again
    check("single_busy_release", {31'd0, busy}, 32'd1);
    tick();                                   // RELEASE -> IDLE
    check("single_busy_done", {31'd0, busy}, 32'd0);
    check("single_data_retained", {16'd0, data_out}, 32'h1234);

    // ---------------- Back-to-back transfers ----------------
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("b2b_ready_%0d", k), {31'd0, event_ready}, 32'd1);
      event_valid = 1'b1;
      event_data  = DATA_W'(k);
      tick();
    end
    event_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      handshake($sformatf("b2b_%0d", k), DATA_W'(k), gap);
      // After req falls, ack_in drops: two sync edges then the direct
      // RELEASE -> REQ pop. Passing through IDLE would cost one more edge.
      if (k > 1) begin
        check($sformatf("b2b_gap_%0d", k), gap, 32'd3);
      end
    end
    tick();
    tick();
    tick();
    check("b2b_busy_done", {31'd0, busy}, 32'd0);

    // ---------------- Overflow, saturation, clear ----------------
    ack_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      event_valid = 1'b1;
      event_data  = 16'hA0 + 16'(i);
      tick();
    end
    check("ovf_data_out",   {16'd0, data_out},    32'h00A0);
    check("ovf_req_out",    {31'd0, req_out},     32'd1);
    check("ovf_ready",      {31'd0, event_ready}, 32'd0);
    check("ovf_drop_count", {24'd0, drop_count},  32'd1);
    check("ovf_overflow",   {31'd0, overflow},    32'd1);
    event_data = 16'hDEAD;
    for (int i = 0; i < 299; i++) begin
      tick();
    end
    check("sat_drop_count", {24'd0, drop_count}, 32'd255);
    clear_overflow = 1'b1;                    // with event_valid still high
    tick();
    check("clr_drop_wins_count", {24'd0, drop_count}, 32'd1);
    check("clr_drop_wins_flag",  {31'd0, overflow},   32'd1);
    event_valid = 1'b0;
    tick();
    clear_overflow = 1'b0;
    check("clr_count", {24'd0, drop_count}, 32'd0);
    check("clr_flag",  {31'd0, overflow},   32'd0);
    for (int i = 0; i < 5; i++) begin
      handshake($sformatf("ovf_drain_%0d", i), 16'hA0 + 16'(i), gap);
    end
    tick();
    tick();
    tick();
    check("ovf_busy_done", {31'd0, busy}, 32'd0);

    // ---------------- Reset mid-handshake ----------------
    for (int i = 0; i < 3; i++) begin
      event_valid = 1'b1;
      event_data  = 16'hC0 + 16'(i);
      tick();
    end
    event_valid = 1'b0;
    check("rmid_in_req", {31'd0, req_out}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rmid_req_out",  {31'd0, req_out},     32'd0);
    check("rmid_data_out", {16'd0, data_out},    32'd0);
    check("rmid_ready",    {31'd0, event_ready}, 32'd1);
    check("rmid_busy",     {31'd0, busy},        32'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    event_valid = 1'b1;
    event_data  = 16'h5555;
    tick();
    event_valid = 1'b0;
    handshake("rmid_new", 16'h5555, gap);
    rises = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (req_out) rises++;
    end
    check("rmid_single_request", rises, 32'd0);
    check("rmid_busy_done", {31'd0, busy}, 32'd0);

    // ---------------- Stuck-high ack at reset release ----------------
    reset  = 1'b1;
    ack_in = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();                                   // ack_s now high
    event_valid = 1'b1;
    event_data  = 16'hBEEF;
    tick();
    event_valid = 1'b0;
    rises = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (req_out) rises++;
    end
    check("stuck_no_req", rises, 32'd0);
    check("stuck_data_zero", {16'd0, data_out}, 32'd0);
    check("stuck_busy", {31'd0, busy}, 32'd1);
    ack_in = 1'b0;
    wait_req("stuck_req_rise", 1'b1, 20, n);
    check("stuck_latency", n, 32'd3);
    check("stuck_data", {16'd0, data_out}, 32'hBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
